alarm_ctrl: RTL
===============

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_SECS, default 60, ring duration in secclk cycles.
REQ-002 Parameter SNOOZE_MIN, default 5, snooze delay in minutes (1..59).
REQ-003 Parameter MAX_SNOOZE, default 3, maximum snoozes per alarm event.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 secclk  in  1  1 Hz clock shared with the time counter; all logic on posedge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 hour, minute, second  in  11 each  current time from the time counter.
REQ-008 week  in  11  current weekday, 1..7 (1 = Monday).
REQ-009 arm  in  1  level; 1 enables the alarm, 0 disarms.
REQ-010 set_en  in  1  load set_hour/set_minute as alarm time this cycle.
REQ-011 set_hour  in  5  alarm hour, 0..23; set_minute  in  6  alarm minute, 0..59.
REQ-012 snooze, stop  in  1 each  user buttons, sampled as levels on posedge.
REQ-013 ring  out  1  buzzer enable, registered.
REQ-014 alarm_hour  out  5; alarm_minute  out  6  stored alarm time, registered.
REQ-015 armed  out  1  high in ARMED, RINGING, SNOOZE.
REQ-016 snooze_cnt  out  2  snoozes used in current alarm event.

Function
REQ-017 States SHALL be IDLE, ARMED, RINGING, SNOOZE; ring = 1 only in RINGING.
REQ-018 Per-edge priority SHALL be: rst > arm=0 > set_en > stop > snooze > match/timeout.
REQ-019 arm=0 in any state SHALL go to IDLE, clearing ring and snooze_cnt; alarm time kept.
REQ-020 set_en with set_hour<=23 and set_minute<=59 SHALL load the alarm time and go to ARMED if arm=1 (else IDLE), clearing snooze_cnt; out-of-range set values SHALL be ignored entirely.
REQ-021 IDLE with arm=1 SHALL go to ARMED next edge.
REQ-022 ARMED SHALL go to RINGING on the edge where hour==alarm_hour, minute==alarm_minute, second==0; ring high from that edge (1-cycle latency), ring counter loaded RING_SECS.
REQ-023 RINGING SHALL decrement the ring counter each edge; after RING_SECS cycles high, go to ARMED with snooze_cnt cleared.
REQ-024 stop in RINGING or SNOOZE SHALL go to ARMED, ring 0, snooze_cnt 0 next edge.
REQ-025 snooze in RINGING with snooze_cnt<MAX_SNOOZE SHALL go to SNOOZE, increment snooze_cnt, and latch target = current hour:minute + SNOOZE_MIN, minute wrapping at 60 with hour carry, hour wrapping 23->0.
REQ-026 snooze in RINGING with snooze_cnt==MAX_SNOOZE SHALL be ignored (keeps ringing).
REQ-027 SNOOZE SHALL go to RINGING when hour:minute equals the target and second==0, reloading RING_SECS.
REQ-028 Held snooze/stop SHALL act only on the first edge of a RINGING/SNOOZE episode it affects; re-entry to RINGING requires a 0 sample first.
REQ-029 Comparisons SHALL use the low bits of the 11-bit inputs; upper bits SHALL be treated as zero-required (nonzero upper bits mean no match).

Reset
REQ-030 rst SHALL set state IDLE, ring 0, armed 0, snooze_cnt 0, alarm_hour 0, alarm_minute 0, ring counter 0, snooze target 0, on the next posedge.
REQ-031 rst mid-ring SHALL drop ring on that edge with no further ringing.

Configuration
REQ-032 Macro ALARM_WORKDAY_EN: when defined, port week_mask in 7 (bit n-1 = weekday n) SHALL exist and ARMED->RINGING (REQ-022) SHALL also require week_mask[week-1]==1; snooze matches unaffected.
REQ-033 Without ALARM_WORKDAY_EN, week_mask SHALL not exist and alarms fire every day.

Verification
REQ-034 set 07:30, arm=1, time 07:29:59 -> 07:30:00 -> ring=1 after that edge, ring=0 exactly 60 cycles later, state ARMED.
REQ-035 ringing at 23:58:10, snooze=1 -> ring=0, snooze_cnt=1; ring=1 again at 00:03:00.
REQ-036 three snoozes taken, fourth snooze press -> ignored, ring stays 1; stop -> ring=0, snooze_cnt=0.
REQ-037 set_en with set_hour=24 -> alarm_hour/alarm_minute unchanged; arm=0 while ringing -> ring=0, IDLE, armed=0.
REQ-038 rst asserted at 07:30:05 during ring -> all outputs 0 after that edge, no ring at 07:30:06.
REQ-039 ALARM_WORKDAY_EN, week_mask=7'b0011111, week=6, alarm time reached -> ring stays 0; week=1 next day -> ring=1.

Source files
------------

// File: rtl/alarm_ctrl_if.sv
// alarm_ctrl_if: time inputs, user controls and alarm status between the time counter/UI and alarm_ctrl; week_mask exists only with ALARM_WORKDAY_EN
interface alarm_ctrl_if;
  logic [10:0] hour;
  logic [10:0] minute;
  logic [10:0] second;
  logic [10:0] week;
  logic        arm;
  logic        set_en;
  logic [4:0]  set_hour;
  logic [5:0]  set_minute;
  logic        snooze;
  logic        stop;
  logic        ring;
  logic [4:0]  alarm_hour;
  logic [5:0]  alarm_minute;
  logic        armed;
  logic [1:0]  snooze_cnt;
`ifdef ALARM_WORKDAY_EN
  logic [6:0]  week_mask;
`endif
  modport master (
`ifdef ALARM_WORKDAY_EN
    output week_mask,
`endif
    output hour, minute, second, week, arm, set_en, set_hour, set_minute, snooze, stop,
    input  ring, alarm_hour, alarm_minute, armed, snooze_cnt
  );
  modport slave (
`ifdef ALARM_WORKDAY_EN
    input  week_mask,
`endif
    input  hour, minute, second, week, arm, set_en, set_hour, set_minute, snooze, stop,
    output ring, alarm_hour, alarm_minute, armed, snooze_cnt
  );
endinterface

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm clock FSM with ring timeout and snooze; ALARM_WORKDAY_EN adds a weekday mask on alarm firing
module alarm_ctrl #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input logic         secclk,
  input logic         rst,
  alarm_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;
  localparam int CW = $clog2(RING_SECS + 1);
  state_t        state;
  logic [CW-1:0] ring_cnt;
  logic [4:0]    tgt_hour;
  logic [5:0]    tgt_minute;
  logic          snooze_lock;
  logic          stop_lock;
  logic          set_ok;
  logic          day_ok;
  logic          now_alarm;
  logic          now_tgt;
  logic          snooze_go;
  logic          stop_go;
  logic [6:0]    min_sum;
  logic [4:0]    snz_hour;
  logic [5:0]    snz_minute;
`ifdef ALARM_WORKDAY_EN
  assign day_ok = bus.week >= 11'd1 && bus.week <= 11'd7 && bus.week_mask[bus.week[2:0] - 3'd1];
`else
  logic unused_week;
  assign unused_week = ^bus.week;
  assign day_ok = 1'b1;
`endif
  // match detection, snooze target arithmetic and button gating (a button acts once, then needs a 0 sample)
  always_comb begin
    set_ok     = bus.set_en && bus.set_hour <= 5'd23 && bus.set_minute <= 6'd59;
    now_alarm  = bus.hour == {6'd0, bus.alarm_hour} && bus.minute == {5'd0, bus.alarm_minute} && bus.second == 11'd0 && day_ok;
    now_tgt    = bus.hour == {6'd0, tgt_hour} && bus.minute == {5'd0, tgt_minute} && bus.second == 11'd0;
    min_sum    = {1'b0, bus.minute[5:0]} + 7'(SNOOZE_MIN);
    snz_minute = min_sum >= 7'd60 ? 6'(min_sum - 7'd60) : min_sum[5:0];
    snz_hour   = min_sum < 7'd60 ? bus.hour[4:0] : bus.hour[4:0] == 5'd23 ? 5'd0 : bus.hour[4:0] + 5'd1;
    stop_go    = bus.arm && !set_ok && bus.stop && !stop_lock && (state == RINGING || state == SNOOZE);
    snooze_go  = bus.arm && !set_ok && !stop_go && bus.snooze && !snooze_lock && state == RINGING && bus.snooze_cnt < 2'(MAX_SNOOZE);
  end
  // alarm state machine with registered outputs; priority arm=0 > set > stop > snooze > match/timeout
  always_ff @(posedge secclk) begin
    if (rst) begin
      state            <= IDLE;
      bus.ring         <= 1'b0;
      bus.armed        <= 1'b0;
      bus.snooze_cnt   <= 2'd0;
      bus.alarm_hour   <= 5'd0;
      bus.alarm_minute <= 6'd0;
      ring_cnt         <= '0;
      tgt_hour         <= 5'd0;
      tgt_minute       <= 6'd0;
      snooze_lock      <= 1'b0;
      stop_lock        <= 1'b0;
    end else begin
      snooze_lock <= bus.snooze && (snooze_lock || snooze_go);
      stop_lock   <= bus.stop && (stop_lock || stop_go);
      if (set_ok) begin
        bus.alarm_hour   <= bus.set_hour;
        bus.alarm_minute <= bus.set_minute;
      end
      if (!bus.arm) begin
        state          <= IDLE;
        bus.ring       <= 1'b0;
        bus.armed      <= 1'b0;
        bus.snooze_cnt <= 2'd0;
      end else if (set_ok || stop_go) begin
        state          <= ARMED;
        bus.ring       <= 1'b0;
        bus.armed      <= 1'b1;
        bus.snooze_cnt <= 2'd0;
      end else if (snooze_go) begin
        state          <= SNOOZE;
        bus.ring       <= 1'b0;
        bus.snooze_cnt <= bus.snooze_cnt + 2'd1;
        tgt_hour       <= snz_hour;
        tgt_minute     <= snz_minute;
      end else begin
        case (state)
          IDLE: begin
            state     <= ARMED;
            bus.armed <= 1'b1;
          end
          ARMED: if (now_alarm) begin
            state    <= RINGING;
            bus.ring <= 1'b1;
            ring_cnt <= CW'(RING_SECS);
          end
          RINGING: if (ring_cnt <= CW'(1)) begin
            state          <= ARMED;
            bus.ring       <= 1'b0;
            bus.snooze_cnt <= 2'd0;
            ring_cnt       <= '0;
          end else ring_cnt <= ring_cnt - CW'(1);
          SNOOZE: if (now_tgt) begin
            state    <= RINGING;
            bus.ring <= 1'b1;
            ring_cnt <= CW'(RING_SECS);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
